ma_mem_access_ctrl: RTL and testbench
=====================================

// Module: ma_mem_access_ctrl
// PURPOSE
//  Memory-access (MA) stage controller, directly downstream of the EX/MA pipeline register.
//  Consumes that register's outputs: mem_read/mem_write/func_3/ALU_out/DATA_2.
//  Runs a req/ack handshake to a word-wide data memory, with byte enables and store-data lane alignment.
//  Returns sign/zero-extended load data and stalls the pipeline (busywait) until the access completes.
// PARAMETERS
//  ADDR_W  32  byte-address width (mem_addr = ADDR_W-2 word address)
// PORTS
//  CLK          in   1   clock, rising edge
//  RESET_N      in   1   asynchronous, active-low reset
//  mem_read     in   1   load request (from EX/MA register)
//  mem_write    in   1   store request (from EX/MA register)
//  func_3       in   3   access size/sign (RV32 load/store funct3)
//  ALU_out      in   32  byte address
//  DATA_2       in   32  store data, unaligned (value in low bits)
//  mem_req      out  1   memory request, held until mem_ack
//  mem_we       out  1   1=write, 0=read
//  mem_addr     out  30  word address = ALU_out[31:2]
//  mem_be       out  4   byte enables
//  mem_wdata    out  32  store data shifted to byte lane
//  mem_rdata    in   32  read word, valid with mem_ack
//  mem_ack      in   1   one-cycle completion pulse
//  load_data    out  32  registered, extended load result
//  busywait     out  1   stall to PC/IF/ID/EX and EX/MA register
//  misaligned   out  1   exception pulse (only with macro, else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE; mem_req, mem_we, mem_be, mem_wdata, load_data, misaligned = 0; mem_addr = 0.
//  FSM IDLE -> REQ -> DONE -> IDLE.
//  - IDLE: access = mem_read|mem_write with legal func_3. If access, busywait=1 combinationally in the same cycle.
//    Next edge: register mem_addr/mem_be/mem_wdata/mem_we and assert mem_req; go REQ.
//  - REQ: mem_req=1, outputs stable, busywait=1.
//    On mem_ack: capture extended mem_rdata into load_data (loads only; stores leave it unchanged), drop mem_req, go DONE.
//    If ack arrives in the same cycle that mem_req is first seen, that is legal.
//  - DONE: busywait=0 for exactly one cycle so the pipeline advances; unconditionally return to IDLE.
//    The EX/MA inputs change only at that edge.
//  Min access latency: 3 cycles (IDLE detect, REQ+ack, DONE).
//  mem_read & mem_write both 1: write wins; read ignored.
//  func_3 legality:
//  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//  - Stores: 000 SB, 001 SH, 010 SW.
//  - Other codes: no access; busywait stays 0; load_data unchanged.
//  Byte enables:
//  - SB: be = 4'b0001 << addr[1:0].
//  - SH: be = 4'b0011 << {addr[1],1'b0}.
//  - SW: be = 4'b1111.
//  - Reads: be = 4'b1111.
//  wdata: DATA_2 replicated across lanes (byte x4, half x2, word as-is).
//  Load extract: byte/half selected by addr[1:0] / addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
//  Reset mid-access: returns to IDLE immediately and mem_req drops asynchronously. The memory must tolerate the abandoned request.
// CONFIGURATION
//  MA_MISALIGN_TRAP_EN defined:
//  - Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
//  - No memory access; misaligned=1 for one cycle in IDLE; busywait stays 0; load_data unchanged.
//  MA_MISALIGN_TRAP_EN undefined:
//  - Low address bits are ignored to force natural alignment (half uses addr[1] only; word ignores addr[1:0]).
//  - misaligned tied 0.
// STRUCTURE
//  Package rv32_mem_pkg:
//  - func_3 localparams (F3_B/H/W/BU/HU).
//  - FSM state encodings (ST_IDLE/ST_REQ/ST_DONE, 2 bits).
//  - be/lane helper functions.
//  Sub-module ma_load_align: combinational. Inputs (rdata, addr[1:0], func_3) -> extended 32-bit word.
//  The FSM, request registers and busywait stay in the top.
// TESTING
//  1. SW addr=0x100 DATA_2=0xDEADBEEF, ack after 2 cycles -> mem_addr=0x40, be=1111, wdata=0xDEADBEEF; busywait 1 until DONE.
//  2. SB addr=0x103 DATA_2=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; one mem_req transaction only.
//  3. LB addr=0x102, rdata=0x12F03456 -> load_data=0xFFFFFFF0. LBU same stimulus -> 0x000000F0. LHU addr=0x102 -> 0x000012F0.
//  4. mem_read=mem_write=1 with SW func_3 -> mem_we=1. Illegal func_3=011 load -> no mem_req, busywait=0.
//  5. Assert RESET_N=0 during REQ -> mem_req=0 and state IDLE at once; after release, new LW completes normally.
//  6. LW addr=0x101:
//  - with MA_MISALIGN_TRAP_EN: misaligned pulse, no mem_req.
//  - without: mem_addr=0x40, load_data=rdata.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - RV32 load/store funct3 codes, MA FSM states and lane helpers
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_write);
    if (is_write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Reads always fetch the whole word; the lane is picked on the way back.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic is_write,
                                         input logic [1:0] lo);
    if (!is_write) return 4'b1111;
    case (f3)
      F3_B:    return 4'b0001 << lo;
      F3_H:    return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_B:    return {4{data[7:0]}};
      F3_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/ma_load_align.sv
// rtl/ma_load_align.sv - selects the addressed byte/half of a read word and extends it
module ma_load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  func_3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (func_3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/ma_mem_access_ctrl.sv
// rtl/ma_mem_access_ctrl.sv - MA stage req/ack memory controller with pipeline stall
// Optional MA_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing alignment.
module ma_mem_access_ctrl
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        func_3,
  input  logic [ADDR_W-1:0] ALU_out,
  input  logic [31:0]       DATA_2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       load_data,
  output logic              busywait,
  output logic              misaligned
);

  state_t      state;
  logic [1:0]  addr_lo_q;
  logic [2:0]  func_3_q;
  logic [31:0] load_ext;
  logic        access;
  logic        go;

  // A simultaneous read and write is treated as a write.
  assign access = (mem_read | mem_write) & f3_legal(func_3, mem_write);

`ifdef MA_MISALIGN_TRAP_EN
  logic mis_detect;
  assign mis_detect = access & addr_misaligned(func_3, ALU_out[1:0]);
  assign go         = access & ~mis_detect;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) misaligned <= 1'b0;
    else          misaligned <= (state == ST_IDLE) && mis_detect;
  end
`else
  assign go         = access;
  assign misaligned = 1'b0;
`endif

  assign busywait = (state == ST_REQ) || ((state == ST_IDLE) && go);

  ma_load_align u_load_align (
    .rdata  (mem_rdata),
    .addr   (addr_lo_q),
    .func_3 (func_3_q),
    .data   (load_ext)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      load_data <= 32'd0;
      addr_lo_q <= 2'd0;
      func_3_q  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            mem_addr  <= ALU_out[ADDR_W-1:2];
            mem_be    <= lane_be(func_3, mem_write, ALU_out[1:0]);
            mem_wdata <= mem_write ? lane_wdata(func_3, DATA_2) : 32'd0;
            mem_we    <= mem_write;
            addr_lo_q <= ALU_out[1:0];
            func_3_q  <= func_3;
            mem_req   <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (!mem_we) load_data <= load_ext;
            mem_req <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_mem_access_ctrl.sv
// tb/tb_ma_mem_access_ctrl.sv - directed self-checking bench for ma_mem_access_ctrl
module tb_ma_mem_access_ctrl;

  logic        CLK;
  logic        RESET_N;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func_3;
  logic [31:0] ALU_out;
  logic [31:0] DATA_2;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] load_data;
  logic        busywait;
  logic        misaligned;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int snap;

  ma_mem_access_ctrl #(.ADDR_W(32)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .func_3     (func_3),
    .ALU_out    (ALU_out),
    .DATA_2     (DATA_2),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .load_data  (load_data),
    .busywait   (busywait),
    .misaligned (misaligned)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge mem_req) req_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; func_3 = 3'd0; ALU_out = 32'd0; DATA_2 = 32'd0;
  endtask

  // Drives one access and plays the memory: ack after nreq REQ cycles.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdata, input int nreq,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_ld);
    mem_read = rd; mem_write = wr; func_3 = f3; ALU_out = addr; DATA_2 = data;
    #1;
    chk("idle_busywait", busywait, 32'd1);
    @(posedge CLK); #1;
    chk("req_asserted", mem_req, 32'd1);
    chk("req_we", mem_we, {31'd0, wr});
    chk("req_addr", mem_addr, addr >> 2);
    chk("req_be", mem_be, exp_be);
    if (wr) chk("req_wdata", mem_wdata, exp_wdata);
    for (int i = 1; i < nreq; i++) begin
      @(posedge CLK); #1;
      chk("req_hold", mem_req, 32'd1);
      chk("req_busywait", busywait, 32'd1);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(posedge CLK); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    chk("done_busywait", busywait, 32'd0);
    chk("done_req", mem_req, 32'd0);
    chk("load_data", load_data, exp_ld);
    @(posedge CLK); #1;
    clear_inputs();
  endtask

  initial begin
    RESET_N = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", mem_req, 32'd0);
    chk("rst_we", mem_we, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be", mem_be, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_busywait", busywait, 32'd0);
    chk("rst_misaligned", misaligned, 32'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // stores: SW, SB to lane 3, SH to upper half
    snap = req_cnt;
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 4'b1111, 32'hDEADBEEF, 32'h0);
    chk("sw_one_req", req_cnt - snap, 32'd1);
    snap = req_cnt;
    run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0);
    chk("sb_one_req", req_cnt - snap, 32'd1);
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0);

    // loads with sign/zero extension
    run_access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h12F03456, 1, 4'b1111, 32'h0, 32'hFFFFFFF0);
    run_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h12F03456, 2, 4'b1111, 32'h0, 32'h000000F0);
    run_access(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h00008001, 1, 4'b1111, 32'h0, 32'hFFFF8001);
    run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h12F03456, 3, 4'b1111, 32'h0, 32'h000012F0);

    // read and write together: write wins, load_data untouched
    run_access(1'b1, 1'b1, 3'b010, 32'h200, 32'h11223344, 32'hFFFFFFFF, 1, 4'b1111, 32'h11223344, 32'h000012F0);

    // illegal funct3 codes
    snap = req_cnt;
    mem_read = 1'b1; func_3 = 3'b011; ALU_out = 32'h100;
    #1;
    chk("ill_load_busywait", busywait, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("ill_load_no_req", mem_req, 32'd0);
    chk("ill_load_req_cnt", req_cnt - snap, 32'd0);
    chk("ill_load_data", load_data, 32'h000012F0);
    clear_inputs();
    mem_write = 1'b1; func_3 = 3'b100; ALU_out = 32'h100;
    #1;
    chk("ill_store_busywait", busywait, 32'd0);
    @(posedge CLK); #1;
    chk("ill_store_no_req", mem_req, 32'd0);
    clear_inputs();

    // reset mid-access, then a fresh LW with ack in the first REQ cycle
    mem_read = 1'b1; func_3 = 3'b010; ALU_out = 32'h10;
    @(posedge CLK); #1;
    chk("mid_req_up", mem_req, 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_load_data", load_data, 32'd0);
    clear_inputs();
    #1;
    chk("mid_rst_idle", busywait, 32'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    run_access(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 32'hCAFEF00D, 1, 4'b1111, 32'h0, 32'hCAFEF00D);

    // misaligned word load
`ifdef MA_MISALIGN_TRAP_EN
    snap = req_cnt;
    mem_read = 1'b1; func_3 = 3'b010; ALU_out = 32'h101;
    #1;
    chk("mis_busywait", busywait, 32'd0);
    @(posedge CLK); #1;
    chk("mis_pulse", misaligned, 32'd1);
    chk("mis_no_req", mem_req, 32'd0);
    clear_inputs();
    @(posedge CLK); #1;
    chk("mis_pulse_end", misaligned, 32'd0);
    chk("mis_req_cnt", req_cnt - snap, 32'd0);
    chk("mis_load_data", load_data, 32'hCAFEF00D);
`else
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h89ABCDEF, 1, 4'b1111, 32'h0, 32'h89ABCDEF);
    chk("mis_tied_zero", misaligned, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
